// File: rtl/clock_set_ctrl.sv
// Set-button front end for the clock counter chain: 1 Hz enable prescaler plus
// synchronized, debounced, auto-repeating hour/minute advance pulses.

module clock_set_btn #(
  parameter int DB_CYC  = 1_000_000,
  parameter int RPT_DLY = 50_000_000,
  parameter int RPT_PER = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic adv,
  output logic held_nxt
);
  localparam int DB_W    = $clog2(DB_CYC + 1);
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DB_ON  = 2'd1;
  localparam logic [1:0] HELD   = 2'd2;
  localparam logic [1:0] REPEAT = 2'd3;

  logic             s1, s;
  logic [1:0]       state, state_n;
  logic [DB_W-1:0]  db_cnt, db_n, lo_cnt, lo_n;
  logic [RPT_W-1:0] rpt_cnt, rpt_n, rpt_inc, rpt_lim;
  logic             adv_n;

  assign rpt_inc  = rpt_cnt + 1'b1;
  assign rpt_lim  = (state == HELD) ? RPT_W'(RPT_DLY) : RPT_W'(RPT_PER);
  // HELD and REPEAT share state[1]; this is the "pressed" view for setting
  assign held_nxt = state_n[1];

  always_comb begin
    state_n = state;
    db_n    = db_cnt;
    lo_n    = lo_cnt;
    rpt_n   = rpt_cnt;
    adv_n   = 1'b0;
    case (state)
      IDLE: if (s) begin
        state_n = DB_ON;
        db_n    = DB_W'(1);
      end
      DB_ON: begin
        if (!s) begin
          state_n = IDLE;
          db_n    = '0;
        end else if (db_cnt == DB_W'(DB_CYC)) begin
          state_n = HELD;
          adv_n   = 1'b1;
          rpt_n   = '0;
          lo_n    = '0;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      default: begin
        // a completed low run wins over a repeat pulse due on the same edge
        if (!s && lo_cnt == DB_W'(DB_CYC)) begin
          state_n = IDLE;
          db_n    = '0;
          lo_n    = '0;
          rpt_n   = '0;
        end else begin
          lo_n = s ? '0 : lo_cnt + 1'b1;
          if (rpt_inc == rpt_lim) begin
            state_n = REPEAT;
            adv_n   = 1'b1;
            rpt_n   = '0;
          end else begin
            rpt_n = rpt_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s       <= 1'b0;
      state   <= IDLE;
      db_cnt  <= '0;
      lo_cnt  <= '0;
      rpt_cnt <= '0;
      adv     <= 1'b0;
    end else begin
      s1      <= btn;
      s       <= s1;
      state   <= state_n;
      db_cnt  <= db_n;
      lo_cnt  <= lo_n;
      rpt_cnt <= rpt_n;
      adv     <= adv_n;
    end
  end
endmodule

module clock_set_ctrl #(
  parameter int CLK_DIV = 100_000_000,
  parameter int DB_CYC  = 1_000_000,
  parameter int RPT_DLY = 50_000_000,
  parameter int RPT_PER = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_hr,
  input  logic btn_min,
  output logic enb,
  output logic adv_hr,
  output logic adv_min,
  output logic setting
);
  localparam int NUM_LANES = 2;
  localparam int DIV_W     = $clog2(CLK_DIV + 1);

  logic [NUM_LANES-1:0] btn, adv, held_nxt;
  logic [DIV_W-1:0]     div_cnt;
  logic                 hold;

  assign btn     = {btn_min, btn_hr};
  assign adv_hr  = adv[0];
  assign adv_min = adv[1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_btn
    clock_set_btn #(
      .DB_CYC (DB_CYC),
      .RPT_DLY(RPT_DLY),
      .RPT_PER(RPT_PER)
    ) u_btn (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn[i]),
      .adv     (adv[i]),
      .held_nxt(held_nxt[i])
    );
  end

  // Freeze from the edge setting rises through the edge it falls, so enb can't
  // share a cycle with the first adv and restarts a full period after release.
  assign hold = setting | (|held_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      enb     <= 1'b0;
      setting <= 1'b0;
    end else begin
      setting <= |held_nxt;
      if (hold) begin
        div_cnt <= '0;
        enb     <= 1'b0;
      end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
        div_cnt <= '0;
        enb     <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        enb     <= 1'b0;
      end
    end
  end
endmodule
